// File: rtl/dawg_pkg.sv
// Shared types and defaults for the DAWG domain scheduler.
// Way/address defaults match the cacheline constants.
package dawg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int DAWG_NUM_WAYS   = 8;
    localparam int DAWG_ADDR_WIDTH = 8;
    localparam int DAWG_DOM_W      = 2;

    typedef logic [DAWG_DOM_W-1:0] dom_id_t;

endpackage

// File: rtl/dawg_rr_arbiter.sv
// Round-robin arbiter: scans upward from the pointer, wrapping; the pointer
// moves to one past the winner when the caller strobes accept.
module dawg_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             accept,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % N);
            if (!gnt_valid && req[cand]) begin
                gnt_valid  = 1'b1;
                gnt_idx    = cand;
                gnt[cand]  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && gnt_valid) begin
            ptr_d = IDX_W'((int'(gnt_idx) + 1) % N);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dawg_domain_sched.sv
// Scheduler sharing one DAWG way-partitioned cacheline between NUM_REQ requesters.
// Build option DAWG_PARTITION_CHECK_EN drops config writes overlapping another domain's ways.
module dawg_domain_sched
    import dawg_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int NUM_DOMAINS = 4,
    parameter int DOM_W       = 2,
    parameter int NUM_WAYS    = DAWG_NUM_WAYS,
    parameter int ADDR_WIDTH  = DAWG_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_we,
    input  logic [DOM_W-1:0]              cfg_dom,
    input  logic [NUM_WAYS-1:0]           cfg_hitmap,
`ifdef DAWG_PARTITION_CHECK_EN
    output logic                          cfg_err,
`endif
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DOM_W-1:0]      req_dom,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic                          resp_hit,
    output logic                          resp_err,
    output logic                          cl_os_req,
    output logic [NUM_WAYS-1:0]           cl_hitmap,
    output logic                          cl_user_req,
    output logic [ADDR_WIDTH-1:0]         cl_addr,
    input  logic                          cl_hit,
    output logic [1:0]                    dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a request is taken in the cycle req_valid[i] and req_ready[i] are both
    // high; dom/addr must be stable then. resp_valid is a one-cycle pulse with no ready.

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [DOM_W-1:0]        dom_q, dom_d, cur_dom_q, cur_dom_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    err_q, err_d;
    logic                    dom_loaded_q, dom_loaded_d;
    logic                    dirty_q, dirty_d;
    logic [NUM_WAYS-1:0]     table_q [NUM_DOMAINS];
    logic [NUM_WAYS-1:0]     table_d [NUM_DOMAINS];

    logic [NUM_REQ-1:0]      gnt;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    gnt_valid;
    logic                    arb_accept;
    logic [DOM_W-1:0]        sel_dom;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    cfg_ok;

    assign arb_accept = (state_q == IDLE) && gnt_valid;

    dawg_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .accept    (arb_accept),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        sel_dom  = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_dom  = req_dom[i*DOM_W +: DOM_W];
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

`ifdef DAWG_PARTITION_CHECK_EN
    logic cfg_err_q, cfg_err_d;

    always_comb begin
        cfg_ok = 1'b1;
        for (int j = 0; j < NUM_DOMAINS; j++) begin
            if (DOM_W'(j) != cfg_dom && (table_q[j] & cfg_hitmap) != '0) begin
                cfg_ok = 1'b0;
            end
        end
        cfg_err_d = cfg_we && !cfg_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;
`else
    assign cfg_ok = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        dom_d        = dom_q;
        addr_d       = addr_q;
        err_d        = err_q;
        cur_dom_d    = cur_dom_q;
        dom_loaded_d = dom_loaded_q;
        dirty_d      = dirty_q;
        table_d      = table_q;
        unique case (state_q)
            IDLE: begin
                if (arb_accept) begin
                    gnt_d  = gnt;
                    dom_d  = sel_dom;
                    addr_d = sel_addr;
                    err_d  = 1'b0;
                    if (table_q[sel_dom] == '0) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (!dom_loaded_q || sel_dom != cur_dom_q || dirty_q) begin
                        state_d = SWITCH;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            SWITCH: begin
                // A same-cycle config write may have emptied the partition; never load an empty mask.
                if (table_q[dom_q] == '0) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cur_dom_d    = dom_q;
                    dom_loaded_d = 1'b1;
                    dirty_d      = 1'b0;
                    state_d      = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Compared against the post-switch domain so a write racing SWITCH forces a re-switch.
        if (cfg_we && cfg_ok) begin
            table_d[cfg_dom] = cfg_hitmap;
            if (cfg_dom == cur_dom_d) begin
                dirty_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            dom_q        <= '0;
            addr_q       <= '0;
            err_q        <= 1'b0;
            cur_dom_q    <= '0;
            dom_loaded_q <= 1'b0;
            dirty_q      <= 1'b0;
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            dom_q        <= dom_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
            cur_dom_q    <= cur_dom_d;
            dom_loaded_q <= dom_loaded_d;
            dirty_q      <= dirty_d;
            table_q      <= table_d;
        end
    end

    assign req_ready   = (state_q == IDLE) ? gnt : '0;
    assign resp_valid  = (state_q == RESP) ? gnt_q : '0;
    assign resp_hit    = (state_q == RESP) && !err_q && cl_hit;
    assign resp_err    = (state_q == RESP) && err_q;
    assign cl_os_req   = (state_q == SWITCH) && (table_q[dom_q] != '0);
    assign cl_hitmap   = cl_os_req ? table_q[dom_q] : '0;
    assign cl_user_req = (state_q == ACCESS);
    assign cl_addr     = cl_user_req ? addr_q : '0;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dawg_domain_sched.sv
// Directed bench for dawg_domain_sched with a small way-partitioned cacheline model.
// Covers DAWG_PARTITION_CHECK_EN when that macro is defined for the build.
module tb_dawg_domain_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_dom;
    logic [7:0]  cfg_hitmap;
    logic [3:0]  req_valid;
    logic [7:0]  req_dom;
    logic [31:0] req_addr;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic        resp_hit;
    logic        resp_err;
    logic        cl_os_req;
    logic [7:0]  cl_hitmap;
    logic        cl_user_req;
    logic [7:0]  cl_addr;
    logic        cl_hit;
    logic [1:0]  dbg_state;
`ifdef DAWG_PARTITION_CHECK_EN
    logic        cfg_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dawg_domain_sched #(
        .NUM_REQ(4), .NUM_DOMAINS(4), .DOM_W(2), .NUM_WAYS(8), .ADDR_WIDTH(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_dom     (cfg_dom),
        .cfg_hitmap  (cfg_hitmap),
`ifdef DAWG_PARTITION_CHECK_EN
        .cfg_err     (cfg_err),
`endif
        .req_valid   (req_valid),
        .req_dom     (req_dom),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .resp_err    (resp_err),
        .cl_os_req   (cl_os_req),
        .cl_hitmap   (cl_hitmap),
        .cl_user_req (cl_user_req),
        .cl_addr     (cl_addr),
        .cl_hit      (cl_hit),
        .dbg_state   (dbg_state)
    );

    wire [29:0] all_outs = {req_ready, resp_valid, resp_hit, resp_err, cl_os_req,
                            cl_hitmap, cl_user_req, cl_addr, dbg_state};

    // Cacheline model: hit if a way inside the loaded mask holds the tag, else fill.
    logic [7:0] way_tag [8];
    logic [7:0] way_v;
    logic [7:0] cur_mask;

    always @(posedge clk) begin
        int  f;
        bit  h;
        if (reset) begin
            way_v    <= '0;
            cur_mask <= '0;
            cl_hit   <= 1'b0;
        end else begin
            cl_hit <= 1'b0;
            if (cl_os_req) cur_mask <= cl_hitmap;
            if (cl_user_req) begin
                h = 1'b0;
                f = -1;
                for (int w = 0; w < 8; w++)
                    if (cur_mask[w] && way_v[w] && way_tag[w] == cl_addr) h = 1'b1;
                for (int w = 7; w >= 0; w--)
                    if (cur_mask[w] && !way_v[w]) f = w;
                if (f < 0)
                    for (int w = 7; w >= 0; w--)
                        if (cur_mask[w]) f = w;
                if (h) cl_hit <= 1'b1;
                else if (f >= 0) begin
                    way_v[f]   <= 1'b1;
                    way_tag[f] <= cl_addr;
                end
            end
        end
    end

    // Observed transaction: cycle offsets from accept (8'hFF = never seen).
    bit          acc_ok;
    int          os_cyc, user_cyc, resp_cyc;
    logic [7:0]  os_map, user_addr;
    logic [3:0]  resp_vec;
    logic        resp_hit_s, resp_err_s;
    logic [45:0] trace;

    function automatic logic [45:0] mk_trace(input int os, input logic [7:0] map, input int us,
                                             input logic [7:0] a, input int rs, input logic [3:0] v,
                                             input logic h, input logic e);
        return {8'(os), map, 8'(us), a, 8'(rs), v, h, e};
    endfunction

    task automatic do_reset();
        reset = 1'b1; cfg_we = 1'b0; cfg_dom = '0; cfg_hitmap = '0;
        req_valid = '0; req_dom = '0; req_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic cfg_write(input int d, input logic [7:0] m);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_dom = 2'(d); cfg_hitmap = m;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic run_req(input int r, input int d, input logic [7:0] a);
        int wc;
        acc_ok = 1'b0; os_cyc = -1; user_cyc = -1; resp_cyc = -1;
        os_map = '0; user_addr = '0; resp_vec = '0; resp_hit_s = 1'b0; resp_err_s = 1'b0;
        @(posedge clk); #1;
        req_valid[r] = 1'b1; req_dom[r*2 +: 2] = 2'(d); req_addr[r*8 +: 8] = a;
        wc = 0;
        while (!acc_ok && wc < 20) begin
            @(negedge clk);
            if (req_ready[r]) acc_ok = 1'b1;
            else begin @(posedge clk); #1; wc++; end
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        if (acc_ok) begin
            for (int k = 1; k <= 6 && resp_cyc < 0; k++) begin
                @(negedge clk);
                if (cl_os_req && os_cyc < 0) begin os_cyc = k; os_map = cl_hitmap; end
                if (cl_user_req && user_cyc < 0) begin user_cyc = k; user_addr = cl_addr; end
                if (resp_valid != '0) begin
                    resp_cyc = k; resp_vec = resp_valid; resp_hit_s = resp_hit; resp_err_s = resp_err;
                end
            end
        end
        trace = mk_trace(os_cyc, os_map, user_cyc, user_addr, resp_cyc, resp_vec, resp_hit_s, resp_err_s);
    endtask

    task automatic test_reset();
        logic [45:0] exp;
        do_reset();
        @(negedge clk);
        n_vec++;
        if (all_outs !== 30'd0) begin n_err++; $display("FAIL reset_outs: got %h want 0", all_outs); end
        // Empty table after reset: dom0 request is rejected at T+1.
        run_req(0, 0, 8'h12);
        exp = mk_trace(-1, 8'h00, -1, 8'h00, 1, 4'b0001, 1'b0, 1'b1);
        n_vec++;
        if (trace !== exp) begin n_err++; $display("FAIL reset_table_empty: got %h want %h", trace, exp); end
    endtask

    task automatic test_switch_then_hit();
        logic [45:0] exp;
        cfg_write(0, 8'h0F);
        run_req(0, 0, 8'h12);
        exp = mk_trace(1, 8'h0F, 2, 8'h12, 3, 4'b0001, 1'b0, 1'b0);
        n_vec++;
        if (!acc_ok || trace !== exp) begin n_err++; $display("FAIL first_switch: got %h want %h acc %0d", trace, exp, acc_ok); end
        run_req(0, 0, 8'h12);
        exp = mk_trace(-1, 8'h00, 1, 8'h12, 2, 4'b0001, 1'b1, 1'b0);
        n_vec++;
        if (!acc_ok || trace !== exp) begin n_err++; $display("FAIL same_dom_hit: got %h want %h acc %0d", trace, exp, acc_ok); end
    endtask

    task automatic test_domain_alternate();
        logic [45:0] exp;
        logic [7:0]  maps [2];
        logic        hits [4];
        maps[0] = 8'h0F; maps[1] = 8'hF0;
        hits[0] = 1'b0; hits[1] = 1'b1; hits[2] = 1'b1; hits[3] = 1'b1;
        cfg_write(1, 8'hF0);
        for (int i = 0; i < 4; i++) begin
            int r;
            r = (i % 2 == 0) ? 1 : 0;
            run_req(r, r, 8'h12);
            exp = mk_trace(1, maps[r], 2, 8'h12, 3, 4'(1 << r), hits[i], 1'b0);
            n_vec++;
            if (!acc_ok || trace !== exp) begin n_err++; $display("FAIL alternate_%0d: got %h want %h", i, trace, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [45:0] exp;
        int ng, last_c;
        // Lone req3 moves the pointer back to 0 before the all-valid run.
        run_req(3, 0, 8'h12);
        exp = mk_trace(-1, 8'h00, 1, 8'h12, 2, 4'b1000, 1'b1, 1'b0);
        n_vec++;
        if (!acc_ok || trace !== exp) begin n_err++; $display("FAIL rr_req3: got %h want %h", trace, exp); end
        @(posedge clk); #1;
        req_valid = 4'hF; req_dom = 8'h00; req_addr = {4{8'h12}};
        ng = 0; last_c = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            @(negedge clk);
            if (req_ready !== 4'b0000) begin
                n_vec++;
                if (req_ready !== 4'(1 << (ng % 4))) begin
                    n_err++; $display("FAIL rr_grant_%0d: got %b want %b", ng, req_ready, 4'(1 << (ng % 4)));
                end
                if (ng > 0) begin
                    n_vec++;
                    if (c - last_c != 3) begin n_err++; $display("FAIL rr_gap_%0d: got %0d want 3", ng, c - last_c); end
                end
                last_c = c;
                ng++;
            end
            if (ng < 5) begin @(posedge clk); #1; end
        end
        n_vec++;
        if (ng != 5) begin n_err++; $display("FAIL rr_grant_count: got %0d want 5", ng); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_empty_partition();
        logic [45:0] exp;
        run_req(2, 2, 8'h44);
        exp = mk_trace(-1, 8'h00, -1, 8'h00, 1, 4'b0100, 1'b0, 1'b1);
        n_vec++;
        if (!acc_ok || trace !== exp) begin n_err++; $display("FAIL empty_partition: got %h want %h", trace, exp); end
    endtask

    task automatic test_cfg_dirty();
        logic [45:0] exp;
        int c;
        fork
            run_req(0, 0, 8'h12);
            begin
                c = 0;
                while (c < 20 && cl_user_req !== 1'b1) begin @(negedge clk); c++; end
                cfg_we = 1'b1; cfg_dom = 2'd0; cfg_hitmap = 8'h03;
                @(posedge clk); #1;
                cfg_we = 1'b0;
            end
        join
        exp = mk_trace(-1, 8'h00, 1, 8'h12, 2, 4'b0001, 1'b1, 1'b0);
        n_vec++;
        if (!acc_ok || trace !== exp) begin n_err++; $display("FAIL dirty_pre: got %h want %h", trace, exp); end
        run_req(0, 0, 8'h12);
        exp = mk_trace(1, 8'h03, 2, 8'h12, 3, 4'b0001, 1'b1, 1'b0);
        n_vec++;
        if (!acc_ok || trace !== exp) begin n_err++; $display("FAIL dirty_reswitch: got %h want %h", trace, exp); end
    endtask

    task automatic test_reset_midop();
        logic [45:0] exp;
        int c;
        fork
            run_req(0, 0, 8'h12);
            begin
                c = 0;
                while (c < 20 && cl_user_req !== 1'b1) begin @(negedge clk); c++; end
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                n_vec++;
                if (all_outs !== 30'd0) begin n_err++; $display("FAIL midop_reset_outs: got %h want 0", all_outs); end
                reset = 1'b0;
            end
        join
        exp = mk_trace(-1, 8'h00, 1, 8'h12, -1, 4'b0000, 1'b0, 1'b0);
        n_vec++;
        if (trace !== exp) begin n_err++; $display("FAIL midop_no_resp: got %h want %h", trace, exp); end
        cfg_write(0, 8'h0F);
        run_req(0, 0, 8'h12);
        exp = mk_trace(1, 8'h0F, 2, 8'h12, 3, 4'b0001, 1'b0, 1'b0);
        n_vec++;
        if (!acc_ok || trace !== exp) begin n_err++; $display("FAIL post_reset_switch: got %h want %h", trace, exp); end
    endtask

    task automatic test_partition_check();
        logic [45:0] exp;
`ifdef DAWG_PARTITION_CHECK_EN
        cfg_write(1, 8'hF0);
        @(negedge clk);
        n_vec++;
        if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_err_clean: got %b want 0", cfg_err); end
        cfg_write(1, 8'h18);
        @(negedge clk);
        n_vec++;
        if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_err_overlap: got %b want 1", cfg_err); end
        run_req(1, 1, 8'h12);
        exp = mk_trace(1, 8'hF0, 2, 8'h12, 3, 4'b0010, 1'b0, 1'b0);
`else
        cfg_write(1, 8'h18);
        run_req(1, 1, 8'h12);
        exp = mk_trace(1, 8'h18, 2, 8'h12, 3, 4'b0010, 1'b0, 1'b0);
`endif
        n_vec++;
        if (!acc_ok || trace !== exp) begin n_err++; $display("FAIL partition_table: got %h want %h", trace, exp); end
    endtask

    initial begin
        test_reset();
        test_switch_then_hit();
        test_domain_alternate();
        test_back_to_back();
        test_empty_partition();
        test_cfg_dirty();
        test_reset_midop();
        test_partition_check();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
